// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) generator/checker for the SD CMD line.
// Absorbs message bits MSB first, then shifts the CRC out MSB first while iunload is high.
module crc7_serial (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = idata ^ crc_q[6];
    crc_d = crc_q;
    if (iunload) begin
      crc_d = {crc_q[5:0], 1'b0};
    end else begin
      // Feedback enters at bit 0 and is folded into the x^3 tap.
      crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      crc_q <= 7'b0000000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign ocrc = crc_q[6];

endmodule

// File: tb/tb_crc7_serial.sv
// Randomized scoreboard bench for crc7_serial: stimulus pushes expected ocrc bits,
// a negedge monitor pops and compares on every cycle flagged for observation.
module tb_crc7_serial;

  logic clk;
  logic irst;
  logic idata;
  logic iunload;
  logic ocrc;
  logic obs;

  int   tests;
  int   fails;
  logic exp_q[$];

  crc7_serial dut (
    .iclk   (clk),
    .irst   (irst),
    .idata  (idata),
    .iunload(iunload),
    .ocrc   (ocrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: remainder of (init * x^n + msg * x^7) mod G by polynomial long division.
  function automatic logic [6:0] crc_model(input logic [6:0] init, input logic [63:0] msg,
                                           input int n);
    logic [127:0] v;
    logic [63:0]  m;
    m = msg & ((64'd1 << n) - 64'd1);
    v = (128'(init) << n) ^ (128'(m) << 7);
    for (int i = n + 6; i >= 7; i--) begin
      if (v[i]) v = v ^ (128'h89 << (i - 7));
    end
    return v[6:0];
  endfunction

  // Monitor: the DUT presents its output on every cycle the stimulus marks with obs.
  always @(negedge clk) begin
    if (obs) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: ocrc=%b observed with no expected bit queued", ocrc);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (ocrc !== e) begin
          fails++;
          $display("FAIL ocrc_bit at %0t: got %b expected %b", $time, ocrc, e);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic u, input logic d, input logic o);
    irst    = r;
    iunload = u;
    idata   = d;
    obs     = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic feed(input logic [63:0] msg, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, msg[i], 1'b0);
  endtask

  // Queue the top k CRC bits (MSB first) followed by extra zeros, then unload that many cycles.
  task automatic unload(input logic [6:0] c, input int k, input int extra);
    for (int i = 6; i > 6 - k; i--) exp_q.push_back(c[i]);
    for (int i = 0; i < extra; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < k + extra; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b1);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m1;
    logic [63:0] m2;
    logic [6:0]  c1;
    logic [6:0]  r;
    int          n1;
    int          n2;
    int          k;

    tests   = 0;
    fails   = 0;
    irst    = 1'b1;
    iunload = 1'b0;
    idata   = 1'b0;
    obs     = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and zero-length message.
    do_reset();
    unload(7'h00, 7, 0);

    // Known SD tokens.
    do_reset();
    feed(64'h40_0000_0000, 40);
    unload(7'h4A, 7, 0);
    do_reset();
    feed(64'h51_0000_0000, 40);
    unload(7'h2A, 7, 5);
    do_reset();
    feed(64'h11_0000_0900, 40);
    unload(7'h33, 7, 0);

    // Reset mid-message discards the partial CRC.
    do_reset();
    feed({$urandom, $urandom}, 20);
    do_reset();
    feed(64'h40_0000_0000, 40);
    unload(7'h4A, 7, 0);

    // Reset with iunload high, mid-unload.
    do_reset();
    feed(64'h51_0000_0000, 40);
    unload(7'h2A, 3, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    unload(7'h00, 1, 2);

    // Checker use: message followed by its CRC leaves the register at zero.
    do_reset();
    feed({17'd0, 40'h40_0000_0000, 7'h4A}, 47);
    unload(7'h00, 7, 0);

    // Random messages of random length, including empty ones.
    for (int t = 0; t < 25; t++) begin
      m1 = {$urandom, $urandom};
      n1 = (t == 0) ? 0 : int'($urandom_range(1, 47));
      do_reset();
      feed(m1, n1);
      unload(crc_model(7'h00, m1, n1), 7, int'($urandom_range(0, 3)));
    end

    // Random checker round-trips: appending the model CRC must give zero.
    for (int t = 0; t < 8; t++) begin
      m1 = {$urandom, $urandom};
      n1 = 40;
      c1 = crc_model(7'h00, m1, n1);
      do_reset();
      feed(m1, n1);
      feed({57'd0, c1}, 7);
      unload(7'h00, 7, 0);
    end

    // Partial unload, then resumed accumulation on the shifted register.
    for (int t = 0; t < 8; t++) begin
      m1 = {$urandom, $urandom};
      m2 = {$urandom, $urandom};
      n1 = int'($urandom_range(1, 40));
      n2 = int'($urandom_range(1, 40));
      k  = int'($urandom_range(1, 6));
      c1 = crc_model(7'h00, m1, n1);
      r  = 7'(c1 << k);
      do_reset();
      feed(m1, n1);
      unload(c1, k, 0);
      feed(m2, n2);
      unload(crc_model(r, m2, n2), 7, 0);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected bits left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc7_serial.md
Name: crc7_serial

Overview:
- Bit-serial CRC7 generator/checker for the SD command line (CMD/response token CRC).
- Polynomial G(x) = x^7 + x^3 + 1 (0x09), initial value 0, no final XOR, message MSB first.
- Sits in the SD transceiver. It absorbs the 40-bit command/response body one bit per clock, then shifts the 7-bit CRC out MSB first on request.

Parameters:
- none (width 7 and polynomial 0x09 are fixed)

Ports:
- iclk  input  1  system clock; all state changes on rising edge
- irst  input  1  synchronous, active-high reset; clears CRC register
- idata  input  1  serial message bit, MSB first; sampled on rising edge when iunload=0
- iunload  input  1  1 = shift-out mode (CRC presented on ocrc); 0 = accumulate mode
- ocrc  output  1  serial CRC output = crc[6], combinational from register

Behaviour:
- State: 7-bit register crc[6:0]. No other state, no FSM.
- Priority on each rising iclk edge: irst > iunload > accumulate.
- Reset: if irst=1 at rising edge, crc <= 7'b0000000.
  - Reset dominates iunload and idata.
  - Reset mid-message or mid-unload discards all progress.
  - ocrc = 0 after reset.
- Accumulate (irst=0, iunload=0): fb = idata XOR crc[6]; crc <= {crc[5], crc[4], crc[3], crc[2] XOR fb, crc[1], crc[0], fb}.
  - One message bit per clock; no valid strobe, every edge consumes idata.
- Unload (irst=0, iunload=1): crc <= {crc[5:0], 1'b0}, a logical left shift with zero fill. idata is ignored.
- ocrc = crc[6] at all times, a pure combinational function of the register (no extra register stage).
  - When iunload rises after the last message bit, CRC bit 6 is already on ocrc before the first unload edge.
  - Downstream logic sampling ocrc on edges 1..7 of unload gets crc[6], crc[5], ... crc[0].
- Latency: 0 cycles from the final data edge to CRC MSB on ocrc. The full CRC is out after 7 unload edges.
- Unload held beyond 7 edges: register is all zero, ocrc = 0 indefinitely.
- iunload deasserted after a partial unload: accumulation resumes on the partially shifted register. This is the defined behaviour; callers reset before each new message.
- A zero-length message gives CRC 0000000.
- Checker use: feed message plus received 7 CRC bits in accumulate mode; the register equals 0 iff no error.
- Synthesizable, single clock domain, no latches, no asynchronous logic.

Test Plan:
- CMD0: reset 1 cycle, feed 40'h40_0000_0000 MSB first, assert iunload, sample ocrc before each of 7 edges -> 1001010 (0x4A).
- CMD17, arg 0: reset, feed 40'h51_0000_0000, unload 7 -> 0101010 (0x2A).
- R1 response to CMD17: reset, feed 40'h11_0000_0900, unload 7 -> 0110011 (0x33).
- Reset mid-message: feed 20 bits of random data, pulse irst 1 cycle, then feed CMD0 body -> 0x4A. Also assert irst with iunload=1 -> register 0, ocrc=0 next cycle.
- Over-unload: after the CMD17 CRC, keep iunload high for 5 more cycles -> ocrc=0 throughout.
- Self-check: reset, feed 40'h40_0000_0000 followed by 7 bits 1001010 in accumulate mode -> register 0000000, ocrc=0.
